// File: rtl/csa_bist_pkg.sv
// rtl/csa_bist_pkg.sv - shared types and constants for the CSA multiplier BIST sequencer
package csa_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    APPLY,
    TEST,
    DONE
  } bist_state_e;

  localparam int DEF_W      = 3;
  localparam int DEF_NCOPY  = 5;
  localparam int DEF_SETTLE = 2;
  localparam int MAX_FAULTS = 2;

endpackage

// File: rtl/csa_bist_golden_mul.sv
// rtl/csa_bist_golden_mul.sv - golden W x W -> 2W unsigned product reference
module csa_bist_golden_mul #(
  parameter int W = 3
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  assign product = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/csa_bist_test_ctrl.sv
// rtl/csa_bist_test_ctrl.sv - BIST sequencer feeding exhaustive operands and golden products
// to the 5-copy CSA array, tracking a sticky fault map and the >2-fault condition.
module csa_bist_test_ctrl
  import csa_bist_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NCOPY  = DEF_NCOPY,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NCOPY-1:0] comp_in,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic [2*W-1:0]   desired_output,
  output logic             init,
  output logic             test,
  output logic             busy,
  output logic             done,
  output logic [NCOPY-1:0] fault_map,
  output logic             uncorrectable
);

  localparam int            PW          = 2 * W;
  localparam logic [PW-1:0] LAST_VEC    = '1;
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);

  function automatic int popcount(input logic [NCOPY-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NCOPY; i++) n += int'(v[i]);
    return n;
  endfunction

  bist_state_e      state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [3:0]       settle_q, settle_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [PW-1:0]    desired_q, desired_d;
  logic             init_q, init_d, test_q, test_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [NCOPY-1:0] fault_map_q, fault_map_d;
  logic             uncorr_q, uncorr_d;
  logic [PW-1:0]    golden_product;

  // Golden product is taken from the next counter value so operands and
  // desired_output land on the same edge.
  csa_bist_golden_mul #(.W(W)) u_golden (
    .a       (cnt_d[W-1:0]),
    .b       (cnt_d[PW-1:W]),
    .product (golden_product)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    init_d      = 1'b0;
    test_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    fault_map_d = fault_map_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = INIT;
          cnt_d       = '0;
          done_d      = 1'b0;
          fault_map_d = '0;
          busy_d      = 1'b1;
          init_d      = 1'b1;
        end
      end
      INIT: begin
        state_d  = APPLY;
        settle_d = SETTLE_LOAD;
      end
      APPLY: begin
        if (settle_q == 4'd0) begin
          state_d = TEST;
          test_d  = 1'b1;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      TEST: begin
        fault_map_d = fault_map_q | comp_in;
        if (cnt_q == LAST_VEC) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + PW'(1);
          state_d  = APPLY;
          settle_d = SETTLE_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    op_a_d    = cnt_d[W-1:0];
    op_b_d    = cnt_d[PW-1:W];
    desired_d = golden_product;
    uncorr_d  = popcount(fault_map_d) > MAX_FAULTS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      desired_q   <= '0;
      init_q      <= 1'b0;
      test_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_map_q <= '0;
      uncorr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      desired_q   <= desired_d;
      init_q      <= init_d;
      test_q      <= test_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_map_q <= fault_map_d;
      uncorr_q    <= uncorr_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign desired_output = desired_q;
  assign init           = init_q;
  assign test           = test_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fault_map      = fault_map_q;
  assign uncorrectable  = uncorr_q;

endmodule

// File: doc/csa_bist_test_ctrl.md
Name: csa_bist_test_ctrl

Overview:
- Built-in self-test sequencer directly upstream of the double-fault selection generator for the 5-copy CSA multiplier array.
- Drives shared test operands to all multiplier copies and a golden expected product (desired_output) to the selection generator.
- Generates the init and test strobes for the selection generator and keeps its own sticky map of faulty copies.
- Flags the case of more than two faulty copies, which double-fault reconfiguration cannot repair.

Parameters:
- W, 3, operand width of each multiplier copy; product width is 2*W.
- NCOPY, 5, number of multiplier copies (width of comp_in and fault_map).
- SETTLE, 2, cycles operands are held before the test strobe (array settle time); legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run a full BIST pass; ignored while busy=1.
- comp_in  input  NCOPY  per-copy mismatch flags returned from the comparator (1 = copy output differs from desired_output).
- op_a  output  W  test operand A, broadcast to all copies.
- op_b  output  W  test operand B, broadcast to all copies.
- desired_output  output  2*W  golden product op_a*op_b.
- init  output  1  one-cycle clear strobe to the selection generator.
- test  output  1  one-cycle sample strobe to the selection generator.
- busy  output  1  high from the cycle after start is accepted until the pass ends.
- done  output  1  sticky pass-complete flag; cleared when the next start is accepted.
- fault_map  output  NCOPY  sticky OR of comp_in sampled in TEST cycles.
- uncorrectable  output  1  high when popcount(fault_map) > 2.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs 0; vector counter 0; settle counter 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State IDLE:
  - start=1 → INIT.
  - On that same edge: clear done, fault_map and the vector counter; set busy=1.
- State INIT:
  - init=1 for exactly one cycle.
  - op_a=0, op_b=0, desired_output=0 on entry.
  - Next state APPLY.
- State APPLY:
  - Operands held stable for SETTLE cycles (settle counter counts SETTLE-1 down to 0).
  - Then → TEST.
- State TEST:
  - test=1 for exactly one cycle.
  - At the end of the cycle: fault_map <= fault_map | comp_in.
  - If the vector counter equals 2^(2W)-1 → DONE.
  - Otherwise increment the counter → APPLY, with the new operands visible in the first APPLY cycle.
- Vector mapping:
  - Counter width is 2*W. op_a = cnt[W-1:0], op_b = cnt[2W-1:W].
  - desired_output = op_a*op_b (unsigned, full 2*W width, no truncation).
  - op_a, op_b and desired_output update on the same edge, so they are never misaligned.
- State DONE:
  - One cycle: busy=0, done=1.
  - Then → IDLE. done holds until the next accepted start.
- Counter wrap: the counter never wraps within a pass; the last vector is all ones (W=3: a=7, b=7, desired=49).
- uncorrectable:
  - Registered from the updated fault_map, so it is valid in the cycle after the TEST edge.
  - Monotonic within a pass.
  - The pass is not aborted; all vectors are still applied.
- start while busy: ignored; it does not restart or extend the pass.
- Reset mid-pass: immediate return to IDLE with all outputs 0. A later start runs a full pass from vector 0.
- comp_in is sampled only in TEST cycles; its value in other states is don't-care.
- Pass length, from start sampled to done=1: 1 (INIT) + 2^(2W)*(SETTLE+1) cycles, plus 1 for DONE. Defaults: 1 + 64*3 + 1 = 194 edges.

Decomposition:
- Package csa_bist_pkg holds:
  - state enumeration: IDLE, INIT, APPLY, TEST, DONE;
  - default constants W=3, NCOPY=5, SETTLE=2;
  - the double-fault limit constant MAX_FAULTS=2.
- One sub-module: csa_bist_golden_mul, a parameterised combinational W x W → 2W unsigned product used as the golden model, so the reference computation is reusable by other stages.
- Popcount and the FSM stay in the top module.

Test Plan:
- Fault-free: comp_in=0, start pulse →
  - exactly 1 init pulse and 64 test pulses;
  - operand sequence (a,b) = (0,0),(1,0)..(7,7);
  - desired matches a*b on every test;
  - done=1 at edge 194; fault_map=0, uncorrectable=0.
- Single fault: comp_in=5'b00100 only in the TEST cycle of vector 21 (a=5, b=2, desired=10) → fault_map=5'b00100 from the next cycle; uncorrectable=0 at done.
- Double fault: comp_in[0] at vector 3 and comp_in[4] at vector 60 → fault_map=5'b10001, uncorrectable=0.
- Triple fault: bits 1, 2, 3 at vectors 8, 9, 10 → uncorrectable=1 from the cycle after vector 10's TEST; pass still runs to vector 63 and done=1.
- Reset mid-pass: rst_n low during vector 20 APPLY → same cycle all outputs 0; after release, a start gives a full 194-edge pass beginning at (0,0).
- Start during busy and a non-TEST comp_in glitch:
  - start pulsed at vector 30 → pass is unaffected;
  - comp_in=5'b11111 during APPLY only → fault_map stays 0.
